// File: rtl/fe_capture_sequencer_pkg.sv
// rtl/fe_capture_sequencer_pkg.sv - state encodings shared by the capture sequencer and register readback
package fe_capture_sequencer_pkg;

    localparam int FE_SEQ_STATE_WIDTH = 3;

    typedef enum logic [FE_SEQ_STATE_WIDTH-1:0] {
        FE_SEQ_S_IDLE    = 3'd0,
        FE_SEQ_S_ARMED   = 3'd1,
        FE_SEQ_S_DELAY   = 3'd2,
        FE_SEQ_S_CAPTURE = 3'd3,
        FE_SEQ_S_DONE    = 3'd4
    } fe_seq_state_e;

endpackage

// File: rtl/fe_capture_sequencer_if.sv
// rtl/fe_capture_sequencer_if.sv - sequencer to front-end capture control/status bundle
interface fe_capture_sequencer_if;

    logic I_trigger;
    logic I_capturing;
    logic I_fifo_full;
    logic O_arm_fe;
    logic O_capture_enable;

    modport master (
        input  I_trigger,
        input  I_capturing,
        input  I_fifo_full,
        output O_arm_fe,
        output O_capture_enable
    );

    modport slave (
        output I_trigger,
        output I_capturing,
        output I_fifo_full,
        input  O_arm_fe,
        input  O_capture_enable
    );

endinterface

// File: rtl/fe_capture_sequencer_down_counter.sv
// rtl/fe_capture_sequencer_down_counter.sv - loadable down counter with zero flag
module pw_load_down_counter #(
    parameter int pWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [pWIDTH-1:0] load_value,
    input  logic              dec,
    output logic              zero
);

    logic [pWIDTH-1:0] count_q;

    // Load wins over decrement; the count saturates at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (load) begin
            count_q <= load_value;
        end else if (dec && (count_q != '0)) begin
            count_q <= count_q - pWIDTH'(1);
        end
    end

    assign zero = (count_q == '0);

endmodule

// File: rtl/fe_capture_sequencer.sv
// rtl/fe_capture_sequencer.sv - arm/trigger/delay/window sequencing for the front-end capture path
module fe_capture_sequencer
    import fe_capture_sequencer_pkg::*;
#(
    parameter int pDELAY_WIDTH      = 20,
    parameter int pCAP_CYCLES_WIDTH = 24,
    parameter int pSEG_WIDTH        = 8
) (
    input  logic                         fe_clk,
    input  logic                         reset_i,
    input  logic                         I_arm,
    input  logic                         I_abort,
    input  logic [pDELAY_WIDTH-1:0]      I_trigger_delay,
    input  logic [pCAP_CYCLES_WIDTH-1:0] I_capture_cycles,
    input  logic [pSEG_WIDTH-1:0]        I_segments,
    fe_capture_sequencer_if.master       fe,
    output logic [FE_SEQ_STATE_WIDTH-1:0] O_state,
    output logic [pSEG_WIDTH-1:0]        O_segment_count,
    output logic                         O_done,
    output logic                         O_trigger_missed,
    output logic                         O_full_stop
);

    fe_seq_state_e state_q, state_d;

    logic arm_r, trig_r;
    logic arm_edge, trig_edge, stop_req;
    logic [pSEG_WIDTH-1:0] seg_target_q, seg_count_q, seg_count_next;
    logic missed_q, full_stop_q, open_ended_q, first_cap_q;

    logic arm_start, delay_load, delay_dec, cap_load, cap_dec;
    logic seg_inc, set_missed, set_full;
    logic delay_zero, cap_zero, window_end;

    assign arm_edge       = I_arm & ~arm_r;
    assign trig_edge      = fe.I_trigger & ~trig_r;
    assign stop_req       = I_abort | ~I_arm;
    assign seg_count_next = seg_count_q + pSEG_WIDTH'(1);

    // Open-ended windows ignore I_capturing on the first cycle while the front end catches up.
    assign window_end = open_ended_q ? (~first_cap_q & ~fe.I_capturing) : cap_zero;

    pw_load_down_counter #(.pWIDTH(pDELAY_WIDTH)) u_delay_ctr (
        .clk        (fe_clk),
        .rst        (reset_i),
        .load       (delay_load),
        .load_value (I_trigger_delay - pDELAY_WIDTH'(1)),
        .dec        (delay_dec),
        .zero       (delay_zero)
    );

    pw_load_down_counter #(.pWIDTH(pCAP_CYCLES_WIDTH)) u_cap_ctr (
        .clk        (fe_clk),
        .rst        (reset_i),
        .load       (cap_load),
        .load_value (I_capture_cycles - pCAP_CYCLES_WIDTH'(1)),
        .dec        (cap_dec),
        .zero       (cap_zero)
    );

    always_comb begin
        state_d    = state_q;
        arm_start  = 1'b0;
        delay_load = 1'b0;
        delay_dec  = 1'b0;
        cap_load   = 1'b0;
        cap_dec    = 1'b0;
        seg_inc    = 1'b0;
        set_missed = 1'b0;
        set_full   = 1'b0;
        case (state_q)
            FE_SEQ_S_IDLE: begin
                if (arm_edge) begin
                    state_d   = FE_SEQ_S_ARMED;
                    arm_start = 1'b1;
                end
            end
            FE_SEQ_S_ARMED: begin
                if (stop_req) begin
                    state_d = FE_SEQ_S_IDLE;
                end else if (trig_edge) begin
                    if (I_trigger_delay == '0) begin
                        state_d  = FE_SEQ_S_CAPTURE;
                        cap_load = 1'b1;
                    end else begin
                        state_d    = FE_SEQ_S_DELAY;
                        delay_load = 1'b1;
                    end
                end
            end
            FE_SEQ_S_DELAY: begin
                if (stop_req) begin
                    state_d = FE_SEQ_S_IDLE;
                end else if (fe.I_fifo_full) begin
                    state_d  = FE_SEQ_S_DONE;
                    set_full = 1'b1;
                end else begin
                    set_missed = trig_edge;
                    if (delay_zero) begin
                        state_d  = FE_SEQ_S_CAPTURE;
                        cap_load = 1'b1;
                    end else begin
                        delay_dec = 1'b1;
                    end
                end
            end
            FE_SEQ_S_CAPTURE: begin
                if (stop_req) begin
                    state_d = FE_SEQ_S_IDLE;
                end else if (fe.I_fifo_full) begin
                    state_d  = FE_SEQ_S_DONE;
                    set_full = 1'b1;
                end else begin
                    set_missed = trig_edge;
                    cap_dec    = 1'b1;
                    if (window_end) begin
                        seg_inc = 1'b1;
                        state_d = (seg_count_next == seg_target_q) ? FE_SEQ_S_DONE : FE_SEQ_S_ARMED;
                    end
                end
            end
            FE_SEQ_S_DONE: begin
                if (!I_arm) begin
                    state_d = FE_SEQ_S_IDLE;
                end
            end
            default: state_d = FE_SEQ_S_IDLE;
        endcase
    end

    always_ff @(posedge fe_clk) begin
        if (reset_i) begin
            state_q      <= FE_SEQ_S_IDLE;
            arm_r        <= 1'b0;
            trig_r       <= 1'b0;
            seg_target_q <= '0;
            seg_count_q  <= '0;
            missed_q     <= 1'b0;
            full_stop_q  <= 1'b0;
            open_ended_q <= 1'b0;
            first_cap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            arm_r       <= I_arm;
            trig_r      <= fe.I_trigger;
            first_cap_q <= cap_load;
            if (cap_load) begin
                open_ended_q <= (I_capture_cycles == '0);
            end
            if (arm_start) begin
                seg_target_q <= (I_segments == '0) ? pSEG_WIDTH'(1) : I_segments;
                seg_count_q  <= '0;
                missed_q     <= 1'b0;
                full_stop_q  <= 1'b0;
            end else begin
                if (seg_inc) begin
                    seg_count_q <= seg_count_next;
                end
                if (set_missed) begin
                    missed_q <= 1'b1;
                end
                if (set_full) begin
                    full_stop_q <= 1'b1;
                end
            end
        end
    end

    assign fe.O_arm_fe         = (state_q == FE_SEQ_S_ARMED) || (state_q == FE_SEQ_S_DELAY) ||
                                 (state_q == FE_SEQ_S_CAPTURE);
    assign fe.O_capture_enable = (state_q == FE_SEQ_S_CAPTURE);
    assign O_done              = (state_q == FE_SEQ_S_DONE);
    assign O_state             = state_q;
    assign O_segment_count     = seg_count_q;
    assign O_trigger_missed    = missed_q;
    assign O_full_stop         = full_stop_q;

endmodule
